// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : video_pkg
//  Description : Shared types and constants for the scanline/sync output
//                stage: scanline dim-level encoding and the latency of the
//                upstream colour/monochrome pipe.
//  Revision    : 1.0 - initial release
// ============================================================================
package video_pkg;

    // Pixel latency (ce_pix cycles) of the colour/monochrome stage ahead of
    // the scanline block; the sync delay defaults to this so syncs line up.
    localparam int VIDEO_PIPE_LAT = 3;

    // Requested scanline dim level.
    typedef enum logic [1:0] {
        SCAN_OFF = 2'b00,   // no dimming
        SCAN_25  = 2'b01,   // x - x/4
        SCAN_50  = 2'b10,   // x/2
        SCAN_75  = 2'b11    // x/4
    } scan_mode_e;

endpackage : video_pkg
`default_nettype wire

// File: rtl/video_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : video_delay_line
//  Description : Pixel-enable gated shift register of DEPTH stages, WIDTH
//                bits wide, with synchronous active-low clear. DEPTH=0 gives
//                a straight wire.
//  Revision    : 1.0 - initial release
// ============================================================================
module video_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk_vid,
    input  logic             reset_n,
    input  logic             ce_pix,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign dout = din;
        end else begin : g_shift
            logic [WIDTH-1:0] r_stage [DEPTH];

            // Shift one stage per pixel; reset clears every stage.
            always_ff @(posedge clk_vid) begin
                if (!reset_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= '0;
                    end
                end else if (ce_pix) begin
                    r_stage[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign dout = r_stage[DEPTH-1];
        end
    endgenerate

endmodule : video_delay_line
`default_nettype wire

// File: rtl/video_scanline_sync.sv
`default_nettype none
// ============================================================================
//  Module      : video_scanline_sync
//  Description : Final video output stage. Re-aligns raw syncs/blanking with
//                a pixel stream that is SYNC_DELAY pixels late, tracks line
//                parity, applies scanline dimming on alternate lines and
//                registers the pixel, syncs and data-enable together.
//  Revision    : 1.0 - initial release
// ============================================================================
module video_scanline_sync
    import video_pkg::*;
#(
    parameter int SYNC_DELAY = VIDEO_PIPE_LAT,
    parameter int DATA_W     = 8
) (
    input  logic              clk_vid,
    input  logic              reset_n,
    input  logic              ce_pix,
    input  logic [DATA_W-1:0] R_IN,
    input  logic [DATA_W-1:0] G_IN,
    input  logic [DATA_W-1:0] B_IN,
    input  logic              HS_IN,
    input  logic              VS_IN,
    input  logic              HBL_IN,
    input  logic              VBL_IN,
    input  logic [1:0]        scan_mode,
    input  logic              scan_phase,
    output logic [DATA_W-1:0] R_OUT,
    output logic [DATA_W-1:0] G_OUT,
    output logic [DATA_W-1:0] B_OUT,
    output logic              HS_OUT,
    output logic              VS_OUT,
    output logic              DE_OUT
);

    // Bit positions inside the delayed sync bundle.
    localparam int SB_HS  = 3;
    localparam int SB_VS  = 2;
    localparam int SB_HBL = 1;
    localparam int SB_VBL = 0;

    logic [3:0]  w_sync_in;
    logic [3:0]  w_sync_d;
    logic        w_hs_d;
    logic        w_vs_d;
    logic        w_de_d;
    logic        w_hs_rise;
    logic        w_vs_rise;

    logic        r_hs_prev;
    logic        r_vs_prev;
    logic        r_line_odd;
    scan_mode_e  r_mode_q;

    logic        w_line_odd_nxt;
    scan_mode_e  w_mode_nxt;
    logic        w_dim;
    logic [DATA_W-1:0] w_r_pix;
    logic [DATA_W-1:0] w_g_pix;
    logic [DATA_W-1:0] w_b_pix;

    // Per-channel dim arithmetic; every result fits in DATA_W.
    function automatic logic [DATA_W-1:0] dim_chan(
        input logic [DATA_W-1:0] x,
        input scan_mode_e        m
    );
        logic [DATA_W-1:0] q;
        q = x >> 2;
        case (m)
            SCAN_25: dim_chan = x - q;
            SCAN_50: dim_chan = x >> 1;
            SCAN_75: dim_chan = q;
            default: dim_chan = x;
        endcase
    endfunction

    assign w_sync_in = {HS_IN, VS_IN, HBL_IN, VBL_IN};

    video_delay_line #(
        .WIDTH (4),
        .DEPTH (SYNC_DELAY)
    ) u_sync_dly (
        .clk_vid (clk_vid),
        .reset_n (reset_n),
        .ce_pix  (ce_pix),
        .din     (w_sync_in),
        .dout    (w_sync_d)
    );

    assign w_hs_d    = w_sync_d[SB_HS];
    assign w_vs_d    = w_sync_d[SB_VS];
    assign w_de_d    = ~w_sync_d[SB_HBL] & ~w_sync_d[SB_VBL];
    assign w_hs_rise = w_hs_d & ~r_hs_prev;
    assign w_vs_rise = w_vs_d & ~r_vs_prev;

    // Next parity / mode; the pixel that coincides with a sync edge already
    // uses the updated values. A VS edge clears parity even if HS also rises.
    always_comb begin
        w_line_odd_nxt = r_line_odd;
        w_mode_nxt     = r_mode_q;
        if (w_vs_rise) begin
            w_line_odd_nxt = 1'b0;
            w_mode_nxt     = scan_mode_e'(scan_mode);
        end else if (w_hs_rise) begin
            w_line_odd_nxt = ~r_line_odd;
        end
    end

    // Pixel selection: blank outside active video, dim on the chosen parity.
    always_comb begin
        w_dim   = (w_mode_nxt != SCAN_OFF) && (w_line_odd_nxt == scan_phase);
        w_r_pix = '0;
        w_g_pix = '0;
        w_b_pix = '0;
        if (w_de_d) begin
            if (w_dim) begin
                w_r_pix = dim_chan(R_IN, w_mode_nxt);
                w_g_pix = dim_chan(G_IN, w_mode_nxt);
                w_b_pix = dim_chan(B_IN, w_mode_nxt);
            end else begin
                w_r_pix = R_IN;
                w_g_pix = G_IN;
                w_b_pix = B_IN;
            end
        end
    end

    // Edge history, line parity and frame-latched dim mode.
    always_ff @(posedge clk_vid) begin
        if (!reset_n) begin
            r_hs_prev  <= 1'b0;
            r_vs_prev  <= 1'b0;
            r_line_odd <= 1'b0;
            r_mode_q   <= SCAN_OFF;
        end else if (ce_pix) begin
            r_hs_prev  <= w_hs_d;
            r_vs_prev  <= w_vs_d;
            r_line_odd <= w_line_odd_nxt;
            r_mode_q   <= w_mode_nxt;
        end
    end

    // Output registers: pixel, syncs and data-enable leave together.
    always_ff @(posedge clk_vid) begin
        if (!reset_n) begin
            R_OUT  <= '0;
            G_OUT  <= '0;
            B_OUT  <= '0;
            HS_OUT <= 1'b0;
            VS_OUT <= 1'b0;
            DE_OUT <= 1'b0;
        end else if (ce_pix) begin
            R_OUT  <= w_r_pix;
            G_OUT  <= w_g_pix;
            B_OUT  <= w_b_pix;
            HS_OUT <= w_hs_d;
            VS_OUT <= w_vs_d;
            DE_OUT <= w_de_d;
        end
    end

endmodule : video_scanline_sync
`default_nettype wire

// File: tb/tb_video_scanline_sync.sv
`default_nettype none
// ============================================================================
//  Module      : tb_video_scanline_sync
//  Description : Directed self-checking bench for video_scanline_sync with
//                SYNC_DELAY=3, DATA_W=8.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_video_scanline_sync;

    logic       clk_vid;
    logic       reset_n;
    logic       ce_pix;
    logic [7:0] R_IN, G_IN, B_IN;
    logic       HS_IN, VS_IN, HBL_IN, VBL_IN;
    logic [1:0] scan_mode;
    logic       scan_phase;
    logic [7:0] R_OUT, G_OUT, B_OUT;
    logic       HS_OUT, VS_OUT, DE_OUT;

    int n_total = 0;
    int n_bad   = 0;

    video_scanline_sync #(
        .SYNC_DELAY (3),
        .DATA_W     (8)
    ) dut (
        .clk_vid    (clk_vid),
        .reset_n    (reset_n),
        .ce_pix     (ce_pix),
        .R_IN       (R_IN),
        .G_IN       (G_IN),
        .B_IN       (B_IN),
        .HS_IN      (HS_IN),
        .VS_IN      (VS_IN),
        .HBL_IN     (HBL_IN),
        .VBL_IN     (VBL_IN),
        .scan_mode  (scan_mode),
        .scan_phase (scan_phase),
        .R_OUT      (R_OUT),
        .G_OUT      (G_OUT),
        .B_OUT      (B_OUT),
        .HS_OUT     (HS_OUT),
        .VS_OUT     (VS_OUT),
        .DE_OUT     (DE_OUT)
    );

    initial clk_vid = 1'b0;
    always #5 clk_vid = ~clk_vid;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Drive one pixel period worth of inputs, clock once, sample 1ns later.
    task automatic step(input logic hs, input logic vs, input logic hbl,
                        input logic vbl, input logic [7:0] pix);
        HS_IN  = hs;
        VS_IN  = vs;
        HBL_IN = hbl;
        VBL_IN = vbl;
        R_IN   = pix;
        G_IN   = pix;
        B_IN   = pix;
        @(posedge clk_vid);
        #1;
    endtask

    // New frame: VS pulse, then the pixel that lands with the delayed VS edge.
    task automatic frame_dim(input logic [1:0] m, input logic [7:0] exp, input string tag);
        scan_mode = m;
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'hC8);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'hC8);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'hC8);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'hC8);
        chk(tag, R_OUT, exp);
    endtask

    // New line with constant 0x80 input; check the first pixel of the line.
    task automatic hs_line(input logic vs, input logic [7:0] exp, input string tag);
        step(1'b1, vs,   1'b0, 1'b0, 8'h80);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h80);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h80);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h80);
        chk(tag, R_OUT, exp);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h80);
    endtask

    initial begin
        reset_n    = 1'b0;
        ce_pix     = 1'b0;
        scan_mode  = 2'b00;
        scan_phase = 1'b0;
        {HS_IN, VS_IN, HBL_IN, VBL_IN} = 4'b0;
        {R_IN, G_IN, B_IN} = '0;

        // Reset with ce_pix low still clears everything.
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'hAA);
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'hAA);
        chk("rst_r",  R_OUT,  8'h00);
        chk("rst_g",  G_OUT,  8'h00);
        chk("rst_b",  B_OUT,  8'h00);
        chk("rst_hs", HS_OUT, 1'b0);
        chk("rst_vs", VS_OUT, 1'b0);
        chk("rst_de", DE_OUT, 1'b0);

        // First frame after reset passes pixels through undimmed.
        reset_n   = 1'b1;
        ce_pix    = 1'b1;
        scan_mode = 2'b11;
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h12);
        chk("pass_r",  R_OUT,  8'h12);
        chk("pass_g",  G_OUT,  8'h12);
        chk("pass_de", DE_OUT, 1'b1);

        // Alignment: HS four samples later, pixel one sample later.
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h55);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h55);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h55);
        chk("align_hs_early", HS_OUT, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h77);
        chk("align_hs", HS_OUT, 1'b1);
        chk("align_r",  R_OUT,  8'h77);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h55);
        chk("align_hs_fall", HS_OUT, 1'b0);

        // Blanking with full-scale pixels.
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'hFF);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'hFF);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'hFF);
        chk("blank_pre_de", DE_OUT, 1'b1);
        chk("blank_pre_r",  R_OUT,  8'hFF);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'hFF);
        chk("blank_de", DE_OUT, 1'b0);
        chk("blank_r",  R_OUT,  8'h00);
        chk("blank_g",  G_OUT,  8'h00);
        chk("blank_b",  B_OUT,  8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'hFF);
        chk("blank_post_de", DE_OUT, 1'b1);

        // Vertical blanking also drops DE.
        step(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'hFF);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'hFF);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'hFF);
        chk("vblank_de", DE_OUT, 1'b0);
        chk("vblank_r",  R_OUT,  8'h00);

        // Dim levels on a dimmed line (parity 0 right after VS).
        scan_phase = 1'b0;
        frame_dim(2'b01, 8'h96, "dim_25");
        chk("dim_vs_out", VS_OUT, 1'b1);
        frame_dim(2'b10, 8'h64, "dim_50");
        frame_dim(2'b11, 8'h32, "dim_75");
        frame_dim(2'b00, 8'hC8, "dim_off");

        // Parity: VS+HS together clear, later lines alternate.
        scan_phase = 1'b1;
        scan_mode  = 2'b10;
        hs_line(1'b1, 8'h80, "par_clear_wins");
        hs_line(1'b0, 8'h40, "par_line1");
        hs_line(1'b0, 8'h80, "par_line2");
        hs_line(1'b0, 8'h40, "par_line3");

        // Mode change mid-frame waits for the next frame.
        scan_phase = 1'b0;
        frame_dim(2'b00, 8'hC8, "latch_off");
        scan_mode = 2'b11;
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'hC8);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'hC8);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'hC8);
        chk("latch_hold", R_OUT, 8'hC8);
        frame_dim(2'b11, 8'h32, "latch_new");
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'hC8);
        chk("latch_vs_fall", VS_OUT, 1'b0);

        // ce_pix low: nothing moves, even with syncs and new pixels applied.
        ce_pix = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b1, 8'h10);
        end
        chk("ce_hold_r",  R_OUT,  8'h32);
        chk("ce_hold_hs", HS_OUT, 1'b0);
        chk("ce_hold_vs", VS_OUT, 1'b0);
        chk("ce_hold_de", DE_OUT, 1'b1);
        ce_pix = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 8'hC8);
            chk("ce_resume_r",  R_OUT,  8'h32);
            chk("ce_resume_hs", HS_OUT, 1'b0);
        end

        // Mid-line reset: one cycle with ce_pix low, then an undimmed frame.
        reset_n = 1'b0;
        ce_pix  = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'hC8);
        chk("rst2_r",  R_OUT,  8'h00);
        chk("rst2_de", DE_OUT, 1'b0);
        reset_n = 1'b1;
        ce_pix  = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'hC8);
        chk("rst2_undimmed", R_OUT, 8'hC8);
        frame_dim(2'b11, 8'h32, "rst2_resync");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_video_scanline_sync
`default_nettype wire
